// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches, tags returned
// words with their PCs, buffers them for decode and flushes on redirects.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);

    localparam int             CW       = $clog2(DEPTH + 1);
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [CW:0]    DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [31:0] tag_mem      [DEPTH];
    logic [31:0] buf_pc_mem   [DEPTH];
    logic [31:0] buf_word_mem [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic resp_fire;
    logic resp_keep;
    logic buf_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Credit counts only registered state, so inst_ready never reaches the request side.
    assign credit_ok      = ({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W;
    assign imem_req_valid = rstn && credit_ok && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign resp_fire = imem_resp_valid && (inflight_q != '0);
    assign resp_keep = resp_fire && (drop_q == '0) && !redirect_valid;

    assign inst_valid  = (count_q != '0) && !redirect_valid;
    assign buf_pop     = inst_valid && inst_ready;
    assign instruction = (count_q != '0) ? buf_word_mem[buf_rd_q] : '0;
    assign inst_pc     = (count_q != '0) ? buf_pc_mem[buf_rd_q]   : '0;

    // Next-state for PC, occupancy counters and FIFO pointers; redirect overrides last.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
        count_d    = count_q + CW'(resp_keep) - CW'(buf_pop);
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = ptr_inc(tag_wr_q);
        end
        if (resp_fire) begin
            tag_rd_d = ptr_inc(tag_rd_q);
            if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
        end
        if (resp_keep) begin
            buf_wr_d = ptr_inc(buf_wr_q);
        end
        if (buf_pop) begin
            buf_rd_d = ptr_inc(buf_rd_q);
        end
        if (redirect_valid) begin
            // Everything still outstanding belongs to the old stream and must be dropped.
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            buf_wr_d   = '0;
            buf_rd_d   = '0;
            drop_d     = inflight_d;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Tag and instruction storage; contents are only visible through valid occupancy.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            buf_pc_mem[buf_wr_q]   <= tag_mem[tag_rd_q];
            buf_word_mem[buf_wr_q] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: queue-based reference model,
// random memory/decode behaviour and directed redirect/reset scenarios.
module tb_inst_fetch_unit;

    localparam int          DEPTH_M = 2;
    localparam logic [31:0] W_RESET = 32'hFFFF_FFF8;
    localparam logic [31:0] SALT    = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // main DUT (DEPTH=2, RESET_PC=0)
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] instruction, inst_pc;

    // second DUT (DEPTH=3, RESET_PC near the top of the address space)
    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_resp_valid;
    logic [31:0] w_resp_data;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_inst_valid, w_inst_ready;
    logic [31:0] w_instruction, w_inst_pc;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH_M)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .inst_pc(inst_pc)
    );

    inst_fetch_unit #(.RESET_PC(W_RESET), .DEPTH(3)) dut_w (
        .clk(clk), .rstn(rstn),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .instruction(w_instruction), .inst_pc(w_inst_pc)
    );

    typedef struct packed { logic [31:0] pc; logic stale; } req_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] word; } ent_t;
    typedef struct packed { logic [31:0] addr; int due; } mem_t;

    req_t        m_inflight[$];
    ent_t        m_buf[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int p_req_ready, p_inst_ready, lat_min, lat_max;
    bit mem_hold;

    bit          o_acc, o_pop, o_iv;
    logic [31:0] o_acc_addr, o_pop_pc;

    bit          w_acc;
    logic [31:0] w_acc_addr;
    logic [31:0] w_addrs[$];
    logic [31:0] w_exp_pc;
    int          w_pops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight.delete();
        m_buf.delete();
        mem_q.delete();
        m_pc     = 32'h0000_0000;
        w_exp_pc = W_RESET;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_valid"},  {31'd0, imem_req_valid}, 32'd0);
        check({pfx, "_req_addr"},   imem_req_addr, 32'h0000_0000);
        check({pfx, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        check({pfx, "_instruction"}, instruction, 32'd0);
        check({pfx, "_inst_pc"},    inst_pc, 32'd0);
        check({pfx, "_w_req_valid"}, {31'd0, w_req_valid}, 32'd0);
        check({pfx, "_w_req_addr"}, w_req_addr, W_RESET);
    endtask

    // One clock cycle: compare against the model, advance model and memory, drive next inputs.
    task automatic step();
        bit          e_req, e_iv, acc_model, pop_model, resp_in, redir;
        logic [31:0] e_instr, e_ipc, rpc;
        req_t        r;
        ent_t        e;
        mem_t        m;
        @(negedge clk);
        e_req   = ((m_inflight.size() + m_buf.size()) < DEPTH_M) && !redirect_valid;
        e_iv    = (m_buf.size() > 0) && !redirect_valid;
        e_instr = (m_buf.size() > 0) ? m_buf[0].word : 32'd0;
        e_ipc   = (m_buf.size() > 0) ? m_buf[0].pc   : 32'd0;
        check("req_valid",   {31'd0, imem_req_valid}, {31'd0, e_req});
        check("req_addr",    imem_req_addr, m_pc);
        check("inst_valid",  {31'd0, inst_valid}, {31'd0, e_iv});
        check("instruction", instruction, e_instr);
        check("inst_pc",     inst_pc, e_ipc);
        o_acc      = imem_req_valid && imem_req_ready;
        o_acc_addr = imem_req_addr;
        o_pop      = inst_valid && inst_ready;
        o_pop_pc   = inst_pc;
        o_iv       = inst_valid;
        w_acc      = w_req_valid;
        w_acc_addr = w_req_addr;
        if (w_inst_valid) begin
            check("w_inst_pc", w_inst_pc, w_exp_pc);
            check("w_instruction", w_instruction, w_exp_pc ^ SALT);
            w_exp_pc += 32'd4;
            w_pops++;
        end
        if (w_acc && w_addrs.size() < 4) w_addrs.push_back(w_acc_addr);
        acc_model = e_req && imem_req_ready;
        pop_model = e_iv && inst_ready;
        resp_in   = imem_resp_valid;
        redir     = redirect_valid;
        rpc       = redirect_pc;
        @(posedge clk);
        cyc++;
        if (pop_model) void'(m_buf.pop_front());
        if (resp_in && m_inflight.size() > 0) begin
            r = m_inflight.pop_front();
            if (!r.stale && !redir) begin
                e.pc   = r.pc;
                e.word = r.pc ^ SALT;
                m_buf.push_back(e);
            end
        end
        if (acc_model) begin
            r.pc = m_pc;
            r.stale = 1'b0;
            m_inflight.push_back(r);
            m_pc += 32'd4;
        end
        if (redir) begin
            foreach (m_inflight[i]) m_inflight[i].stale = 1'b1;
            m_buf.delete();
            m_pc = {rpc[31:2], 2'b00};
        end
        if (o_acc) begin
            m.addr = o_acc_addr;
            m.due  = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
            mem_q.push_back(m);
        end
        #1;
        imem_resp_valid = 1'b0;
        if (!mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = m.addr ^ SALT;
        end
        imem_req_ready = ($urandom_range(99) < p_req_ready);
        inst_ready     = ($urandom_range(99) < p_inst_ready);
        redirect_valid = 1'b0;
        w_resp_valid   = w_acc;
        w_resp_data    = w_acc_addr ^ SALT;
    endtask

    initial begin
        int          first_iv, accepts;
        bit          reached, got;
        logic [31:0] w_exp [4];
        logic [31:0] pops[$];
        logic [31:0] accs[$];
        w_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        rstn = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        w_req_ready = 1'b1; w_inst_ready = 1'b1; w_resp_valid = 1'b0; w_resp_data = '0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0;
        p_req_ready = 100; p_inst_ready = 100; lat_min = 1; lat_max = 1; mem_hold = 1'b0;
        w_pops = 0;
        model_reset();

        // reset state
        @(posedge clk); #1;
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // sequential fetch from reset, 1-cycle memory, decode always ready
        rstn = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
        first_iv = -1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (first_iv < 0 && o_iv) first_iv = i;
        end
        check("first_inst_valid_cycle", first_iv, 32'd2);
        check("w_throughput", w_pops, 32'd22);
        check("w_addr_count", w_addrs.size(), 32'd4);
        for (int i = 0; i < w_addrs.size(); i++) check("w_wrap_addr", w_addrs[i], w_exp[i]);

        // redirect to 0x1003 with two requests outstanding and nothing buffered
        mem_hold = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_inflight.size() == 2 && m_buf.size() == 0) reached = 1'b1;
            else step();
        end
        check("C_setup", {31'd0, reached}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
        step();
        mem_hold = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (o_acc) begin got = 1'b1; check("C_first_req", o_acc_addr, 32'h0000_1000); end
        end
        check("C_req_seen", {31'd0, got}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (o_pop) begin got = 1'b1; check("C_first_pc", o_pop_pc, 32'h0000_1000); end
        end
        check("C_pop_seen", {31'd0, got}, 32'd1);

        // redirect while a response arrives and a buffered entry is valid
        p_inst_ready = 0; inst_ready = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (imem_resp_valid && m_buf.size() > 0) reached = 1'b1;
            else step();
        end
        check("D_setup", {31'd0, reached}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        step();
        check("D_inst_valid", {31'd0, o_iv}, 32'd0);
        p_inst_ready = 100;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (o_pop) begin got = 1'b1; check("D_first_pc", o_pop_pc, 32'h0000_2000); end
        end
        check("D_pop_seen", {31'd0, got}, 32'd1);

        // randomized traffic with occasional redirects
        p_req_ready = 70; p_inst_ready = 60; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
            step();
        end

        // asynchronous reset mid-stream with two requests outstanding
        p_req_ready = 100; p_inst_ready = 100; lat_min = 1; lat_max = 1; mem_hold = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (m_inflight.size() == 2) reached = 1'b1;
            else step();
        end
        check("F_setup", {31'd0, reached}, 32'd1);
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        mem_hold = 1'b0; imem_resp_valid = 1'b0; w_resp_valid = 1'b0;
        @(posedge clk); #1;

        // release with a late stray response, decode stalled
        rstn = 1'b1; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        imem_req_ready = 1'b1; redirect_valid = 1'b0;
        p_inst_ready = 0; inst_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_acc) begin accepts++; accs.push_back(o_acc_addr); end
        end
        check("F_accepts", accepts, 32'd2);
        p_inst_ready = 100; inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_pop) pops.push_back(o_pop_pc);
            if (o_acc) accs.push_back(o_acc_addr);
        end
        check("F_pop_count_min", {31'd0, (pops.size() >= 2)}, 32'd1);
        check("F_acc_count_min", {31'd0, (accs.size() >= 3)}, 32'd1);
        if (accs.size() >= 3) begin
            check("F_req0", accs[0], 32'h0000_0000);
            check("F_req1", accs[1], 32'h0000_0004);
            check("F_req2", accs[2], 32'h0000_0008);
        end
        if (pops.size() >= 2) begin
            check("F_pop0", pops[0], 32'h0000_0000);
            check("F_pop1", pops[1], 32'h0000_0004);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
